// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_REQ requesters.
// Define SRAM_ARB_CLEAR_EN to zero-fill the RAM after reset before serving.
module sram_port_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 8,
  parameter int NUM_REQ       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               we,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             busy,
  output logic [ADDRESS_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]            ram_data_in,
  output logic                             ram_write_enable,
  input  logic [DATA_WIDTH-1:0]            ram_data_out
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

`ifdef SRAM_ARB_CLEAR_EN
  localparam state_t RST_ST = CLEAR;
`else
  localparam state_t RST_ST = RUN;
`endif

  state_t                   state_q, state_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic                     pend_v_q, pend_v_d;
  logic [IW-1:0]            pend_idx_q, pend_idx_d;
  logic [ADDRESS_WIDTH-1:0] hold_q;
`ifdef SRAM_ARB_CLEAR_EN
  logic [ADDRESS_WIDTH-1:0] clr_q, clr_d;
`endif

  logic          found;
  logic [IW-1:0] gidx;
  logic [IW:0]   scan;

  // Rotating scan: first request at or after ptr wins
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    scan  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(NUM_REQ)) begin
        scan = scan - (IW+1)'(NUM_REQ);
      end
      if (!found && req[scan[IW-1:0]]) begin
        found = 1'b1;
        gidx  = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    pend_v_d         = 1'b0;
    pend_idx_d       = pend_idx_q;
    gnt              = '0;
    ram_addr         = hold_q;
    ram_data_in      = '0;
    ram_write_enable = 1'b0;
    busy             = 1'b0;
`ifdef SRAM_ARB_CLEAR_EN
    clr_d            = clr_q;
`endif
    unique case (state_q)
`ifdef SRAM_ARB_CLEAR_EN
      CLEAR: begin
        busy             = 1'b1;
        ram_addr         = clr_q;
        ram_write_enable = 1'b1;
        clr_d            = clr_q + 1'b1;
        if (clr_q == '1) begin
          state_d = RUN;
        end
      end
`endif
      RUN: begin
        if (found) begin
          gnt[gidx]        = 1'b1;
          ram_addr         = addr[gidx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          ram_data_in      = wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
          ram_write_enable = we[gidx];
          pend_v_d         = !we[gidx];
          pend_idx_d       = gidx;
          ptr_d = (gidx == IW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
        end
      end
      default: ;
    endcase
    // Reset masks every RAM-facing output in the same cycle
    if (rst) begin
      gnt              = '0;
      ram_addr         = '0;
      ram_data_in      = '0;
      ram_write_enable = 1'b0;
`ifdef SRAM_ARB_CLEAR_EN
      busy             = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_ST;
      ptr_q      <= '0;
      pend_v_q   <= 1'b0;
      pend_idx_q <= '0;
      hold_q     <= '0;
`ifdef SRAM_ARB_CLEAR_EN
      clr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      pend_v_q   <= pend_v_d;
      pend_idx_q <= pend_idx_d;
      hold_q     <= ram_addr;
`ifdef SRAM_ARB_CLEAR_EN
      clr_q      <= clr_d;
`endif
    end
  end

  assign rvalid = (pend_v_q && !rst) ? (NUM_REQ'(1) << pend_idx_q) : '0;
  assign rdata  = ram_data_out;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural registered-read RAM.
// Honours SRAM_ARB_CLEAR_EN for the post-reset sweep checks.
module tb_sram_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NR = 4;
`ifdef SRAM_ARB_CLEAR_EN
  localparam int SWEEP = 256;
  localparam logic [15:0] RST_RD = 16'h0000;
`else
  localparam int SWEEP = 0;
  localparam logic [15:0] RST_RD = 16'h1234;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req, we, gnt, rvalid;
  logic [NR*AW-1:0]  addr;
  logic [NR*DW-1:0]  wdata;
  logic [DW-1:0]     rdata, ram_data_in, ram_data_out;
  logic [AW-1:0]     ram_addr;
  logic              busy, ram_write_enable;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] raddr_q;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_addr] <= ram_data_in;
    raddr_q <= ram_addr;
  end
  assign ram_data_out = mem[raddr_q];

  sram_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
  );

  typedef struct {
    logic [NR-1:0]    req;
    logic [NR-1:0]    we;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] wdata;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    rv;
    logic [DW-1:0]    rd;
  } vec_t;

  vec_t vecs[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] w,
                     input logic [31:0] a, input logic [63:0] d,
                     input logic [3:0] g, input logic [3:0] v,
                     input logic [15:0] x);
    vec_t t;
    t.req = r; t.we = w; t.addr = a; t.wdata = d;
    t.gnt = g; t.rv = v; t.rd = x;
    vecs.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] w,
                       input logic [31:0] a, input logic [63:0] d);
    req = r; we = w; addr = a; wdata = d;
  endtask

  localparam logic [31:0] RR = {8'd3, 8'd2, 8'd1, 8'd0};

  initial begin
    int cnt;
    // Writes of known data, then reads / round robin
    add(4'b1000, 4'b1000, 32'h10000000, 64'hBEEF000000000000, 4'b1000, 0, 0);
    add(4'b0001, 4'b0001, 32'h00, 64'hA000, 4'b0001, 0, 0);
    add(4'b0001, 4'b0001, 32'h01, 64'hA001, 4'b0001, 0, 0);
    add(4'b0001, 4'b0001, 32'h02, 64'hA002, 4'b0001, 0, 0);
    add(4'b0001, 4'b0001, 32'h03, 64'hA003, 4'b0001, 0, 0);
    add(4'b0010, 4'b0000, 32'h1000, 0, 4'b0010, 0, 0);
    add(4'b0001, 4'b0001, 32'h05, 64'h1234, 4'b0001, 4'b0010, 16'hBEEF);
    add(4'b0001, 4'b0000, 32'h05, 0, 4'b0001, 0, 0);
    add(4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0001, 16'h1234);
    add(4'b0100, 4'b0000, 32'h000000, 0, 4'b0100, 0, 0);
    add(4'b0100, 4'b0000, 32'h010000, 0, 4'b0100, 4'b0100, 16'hA000);
    add(4'b0100, 4'b0000, 32'h020000, 0, 4'b0100, 4'b0100, 16'hA001);
    add(4'b0100, 4'b0000, 32'h030000, 0, 4'b0100, 4'b0100, 16'hA002);
    add(4'b1000, 4'b0000, 32'h0, 0, 4'b1000, 4'b0100, 16'hA003);
    add(4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b1000, 16'hA000);
    add(4'b1111, 4'b0000, RR, 0, 4'b0001, 0, 0);
    add(4'b1111, 4'b0000, RR, 0, 4'b0010, 4'b0001, 16'hA000);
    add(4'b1111, 4'b0000, RR, 0, 4'b0100, 4'b0010, 16'hA001);
    add(4'b1111, 4'b0000, RR, 0, 4'b1000, 4'b0100, 16'hA002);
    add(4'b1111, 4'b0000, RR, 0, 4'b0001, 4'b1000, 16'hA003);
    add(4'b1111, 4'b0000, RR, 0, 4'b0010, 4'b0001, 16'hA000);
    add(4'b1111, 4'b0000, RR, 0, 4'b0100, 4'b0010, 16'hA001);
    add(4'b1111, 4'b0000, RR, 0, 4'b1000, 4'b0100, 16'hA002);
    add(4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b1000, 16'hA003);
    add(4'b0010, 4'b0000, RR, 0, 4'b0010, 0, 0);
    add(4'b1011, 4'b0000, RR, 0, 4'b1000, 4'b0010, 16'hA001);
    add(4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b1000, 16'hA003);

    rst = 1'b1;
    drive(4'b1111, 4'b1111, RR, {4{16'hFFFF}});
    step(); step(); #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_we", ram_write_enable, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_data_in, 0);

    // Release reset with req[3] waiting through any sweep
    step();
    rst = 1'b0;
    drive(vecs[0].req, vecs[0].we, vecs[0].addr, vecs[0].wdata);
    #1;
    cnt = 0;
    while (busy && cnt < 400) begin
      if (ram_write_enable !== 1'b1 || ram_addr !== AW'(cnt) ||
          ram_data_in !== 0 || gnt !== 0)
        chk("sweep_cycle", {ram_write_enable, ram_addr, ram_data_in, gnt},
            {1'b1, AW'(cnt), 16'h0, 4'h0});
      cnt++;
      step(); #1;
    end
    chk("busy_cycles", cnt, SWEEP);
    chk("first_run_gnt", gnt, 4'b1000);

    foreach (vecs[i]) begin
      step();
      drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      #1;
      chk($sformatf("v%0d_gnt", i), gnt, vecs[i].gnt);
      chk($sformatf("v%0d_rvalid", i), rvalid, vecs[i].rv);
      if (vecs[i].rv != 0)
        chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rd);
    end

    // Reset the cycle after a read grant to requester 2 (ptr -> 3)
    step(); drive(4'b0100, 4'b0000, 32'h00050000, 0); #1;
    chk("mid_gnt", gnt, 4'b0100);
    step(); rst = 1'b1; drive(4'b1111, 4'b0000, RR, 0); #1;
    chk("mid_rvalid", rvalid, 0);
    chk("mid_gnt_rst", gnt, 0);
    chk("mid_we", ram_write_enable, 0);
    chk("mid_addr", ram_addr, 0);
    step(); rst = 1'b0; drive(4'b1010, 4'b0000, 32'h00000500, 0); #1;
    chk("mid_busy", busy, SWEEP != 0);
    if (SWEEP != 0) chk("mid_sweep_addr0", {ram_write_enable, ram_addr}, 9'h100);
    cnt = 0;
    while (busy && cnt < 400) begin
      cnt++;
      step(); #1;
    end
    chk("mid_busy_cycles", cnt, SWEEP);
    chk("mid_ptr_reset", gnt, 4'b0010);
    step(); drive(0, 0, 0, 0); #1;
    chk("mid_rd_rvalid", rvalid, 4'b0010);
    chk("mid_rd_rdata", rdata, RST_RD);

`ifdef SRAM_ARB_CLEAR_EN
    step(); drive(4'b0001, 4'b0000, 32'h20, 0); #1;
    step(); drive(0, 0, 0, 0); #1;
    chk("cleared_rdata", rdata, 16'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
